// File: rtl/eth_tx_port_arbiter.sv
`default_nettype none
// ============================================================================
// eth_tx_port_arbiter : packet-level arbiter sharing one 1GbE TX data/status
// FIFO pair between N_REQ decoder ports. Option macro: PRIO_PORT0_EN.
// Revision: 1.0
// ============================================================================
module eth_tx_port_arbiter #(
  parameter int N_REQ    = 2,
  parameter int AVL_SIZE = 8,
  parameter int STATUS_W = 96,
  parameter int MAX_IDLE = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  output logic [N_REQ-1:0]          grant,
  input  logic [N_REQ*AVL_SIZE-1:0] req_data,
  input  logic [N_REQ-1:0]          req_data_write,
  input  logic [N_REQ*STATUS_W-1:0] req_status,
  input  logic [N_REQ-1:0]          req_status_write,
  output logic [N_REQ-1:0]          req_data_full,
  output logic [N_REQ-1:0]          req_status_full,
  output logic [AVL_SIZE-1:0]       tx_fifo_data,
  output logic                      tx_fifo_data_write,
  output logic [STATUS_W-1:0]       tx_fifo_status,
  output logic                      tx_fifo_status_write,
  input  logic                      tx_fifo_data_full,
  input  logic                      tx_fifo_status_full,
  output logic                      drop_err,
  output logic                      timeout_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_IDLE + 1);

  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W-1:0] C_ONE_IDX   = IDX_W'(1);
  localparam logic [N_REQ-1:0] C_ONE_REQ   = N_REQ'(1);
  localparam logic [CNT_W-1:0] C_ONE_CNT   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_IDLE_MAX  = CNT_W'(MAX_IDLE);
  localparam logic [CNT_W-1:0] C_IDLE_LAST = CNT_W'(MAX_IDLE - 1);

  localparam logic [1:0] ST_ARB     = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic [AVL_SIZE-1:0] tx_data_q, tx_data_d;
  logic [STATUS_W-1:0] tx_status_q, tx_status_d;
  logic                tx_dw_q, tx_dw_d;
  logic                tx_sw_q, tx_sw_d;
  logic                drop_err_q, timeout_err_q;

  logic [N_REQ-1:0]    w_rr_req;
  logic [IDX_W-1:0]    w_cand, w_win_idx;
  logic                w_win_valid, w_prio;
  logic [AVL_SIZE-1:0] w_g_data;
  logic [STATUS_W-1:0] w_g_status;
  logic                w_g_req, w_g_dw, w_g_sw, w_idle_tick, w_timeout, w_drop;

  // Winner search walks last+1, last+2, ... wrapping at N_REQ-1.
  always_comb begin
    w_prio   = 1'b0;
    w_rr_req = req;
`ifdef PRIO_PORT0_EN
    w_prio      = req[0];
    w_rr_req[0] = 1'b0;
`endif
    w_win_valid = w_prio;
    w_win_idx   = '0;
    w_cand      = last_q;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = (w_cand == C_LAST_IDX) ? '0 : w_cand + C_ONE_IDX;
      if (!w_win_valid && w_rr_req[w_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_g_data   = '0;
    w_g_status = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        w_g_data   = req_data[i*AVL_SIZE +: AVL_SIZE];
        w_g_status = req_status[i*STATUS_W +: STATUS_W];
      end
    end
  end

  // grant_q is zero outside BUSY, so masking by it covers both drop cases.
  assign w_g_req     = |(req & grant_q);
  assign w_g_dw      = |(req_data_write & grant_q);
  assign w_g_sw      = |(req_status_write & grant_q);
  assign w_drop      = |((req_data_write | req_status_write) & ~grant_q);
  assign w_idle_tick = !w_g_dw && !w_g_sw && !tx_fifo_data_full && !tx_fifo_status_full;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    idle_cnt_d  = idle_cnt_q;
    tx_data_d   = tx_data_q;
    tx_status_d = tx_status_q;
    tx_dw_d     = 1'b0;
    tx_sw_d     = 1'b0;
    w_timeout   = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (w_win_valid) begin
          grant_d    = C_ONE_REQ << w_win_idx;
          state_d    = ST_BUSY;
          idle_cnt_d = '0;
          if (!w_prio) last_d = w_win_idx;
        end
      end
      ST_BUSY: begin
        tx_data_d   = w_g_data;
        tx_status_d = w_g_status;
        tx_dw_d     = w_g_dw;
        tx_sw_d     = w_g_sw;
        if (w_g_dw || w_g_sw)
          idle_cnt_d = '0;
        else if (w_idle_tick && idle_cnt_q != C_IDLE_MAX)
          idle_cnt_d = idle_cnt_q + C_ONE_CNT;
        if (w_g_sw || !w_g_req) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (w_idle_tick && idle_cnt_q == C_IDLE_LAST) begin
          grant_d   = '0;
          state_d   = ST_RELEASE;
          w_timeout = 1'b1;
        end
      end
      ST_RELEASE: state_d = ST_ARB;
      default: begin
        state_d = ST_ARB;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ARB;
      grant_q       <= '0;
      last_q        <= C_LAST_IDX;
      idle_cnt_q    <= '0;
      tx_data_q     <= '0;
      tx_status_q   <= '0;
      tx_dw_q       <= 1'b0;
      tx_sw_q       <= 1'b0;
      drop_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      idle_cnt_q    <= idle_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_status_q   <= tx_status_d;
      tx_dw_q       <= tx_dw_d;
      tx_sw_q       <= tx_sw_d;
      drop_err_q    <= w_drop;
      timeout_err_q <= w_timeout;
    end
  end

  assign grant                = grant_q;
  assign req_data_full        = {N_REQ{tx_fifo_data_full}} | ~grant_q;
  assign req_status_full      = {N_REQ{tx_fifo_status_full}} | ~grant_q;
  assign tx_fifo_data         = tx_data_q;
  assign tx_fifo_data_write   = tx_dw_q;
  assign tx_fifo_status       = tx_status_q;
  assign tx_fifo_status_write = tx_sw_q;
  assign drop_err             = drop_err_q;
  assign timeout_err          = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_port_arbiter.sv
`default_nettype none
// tb_eth_tx_port_arbiter: table-driven packets plus a TX scoreboard queue,
// with hand-written sequences for drop, watchdog, backpressure and mid-packet reset.
module tb_eth_tx_port_arbiter;
  localparam int N  = 2;
  localparam int AW = 8;
  localparam int SW = 96;
  localparam int MI = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    grant;
  logic [N*AW-1:0] req_data = '0;
  logic [N-1:0]    req_data_write = '0;
  logic [N*SW-1:0] req_status = '0;
  logic [N-1:0]    req_status_write = '0;
  logic [N-1:0]    req_data_full, req_status_full;
  logic [AW-1:0]   tx_fifo_data;
  logic            tx_fifo_data_write;
  logic [SW-1:0]   tx_fifo_status;
  logic            tx_fifo_status_write;
  logic            tx_fifo_data_full = 1'b0;
  logic            tx_fifo_status_full = 1'b0;
  logic            drop_err, timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [AW-1:0] exp_data[$];
  logic [SW-1:0] exp_status[$];

  typedef struct {
    int         port;
    int         len;
    logic [7:0] base;
    logic [1:0] exp_grant;
  } pkt_t;

  typedef struct {
    logic       df;
    logic       sf;
    logic [1:0] exp_rdf;
    logic [1:0] exp_rsf;
  } full_vec_t;

  pkt_t      pkts[3];
  full_vec_t fv[4];

  eth_tx_port_arbiter #(.N_REQ(N), .AVL_SIZE(AW), .STATUS_W(SW), .MAX_IDLE(MI)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .req_data(req_data), .req_data_write(req_data_write),
    .req_status(req_status), .req_status_write(req_status_write),
    .req_data_full(req_data_full), .req_status_full(req_status_full),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_data_write(tx_fifo_data_write),
    .tx_fifo_status(tx_fifo_status), .tx_fifo_status_write(tx_fifo_status_write),
    .tx_fifo_data_full(tx_fifo_data_full), .tx_fifo_status_full(tx_fifo_status_full),
    .drop_err(drop_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] mk_status(input int port, input int len, input logic [7:0] base);
    return {16'(len), 32'hC0A8_0001 + 32'(port), 40'h02_0000_0000, base};
  endfunction

  // Scoreboard: every forwarded write must match the oldest expected entry.
  always @(negedge clk) begin
    if (tx_fifo_data_write === 1'b1) begin
      if (exp_data.size() == 0) begin
        n_checks++;
        $display("FAIL tx_data_unexpected: got %0h expected none at %0t", tx_fifo_data, $time);
      end else begin
        check("tx_data", 128'(tx_fifo_data), 128'(exp_data.pop_front()));
      end
    end
    if (tx_fifo_status_write === 1'b1) begin
      if (exp_status.size() == 0) begin
        n_checks++;
        $display("FAIL tx_status_unexpected: got %0h expected none at %0t", tx_fifo_status, $time);
      end else begin
        check("tx_status", 128'(tx_fifo_status), 128'(exp_status.pop_front()));
      end
    end
  end

  task automatic wait_grant(input logic [1:0] exp, input string name);
    int cyc = 0;
    while (grant == '0 && cyc < 50) begin
      step();
      cyc++;
    end
    check(name, 128'(grant), 128'(exp));
  endtask

  task automatic send_body(input int port, input int len, input logic [7:0] base, input bit drop_req);
    logic [SW-1:0] st;
    for (int b = 0; b < len; b++) begin
      req_data[port*AW +: AW] = base + 8'(b);
      req_data_write[port]    = 1'b1;
      exp_data.push_back(base + 8'(b));
      step();
      check("data_latency", 128'(tx_fifo_data_write), 128'(1));
    end
    req_data_write[port] = 1'b0;
    st = mk_status(port, len, base);
    req_status[port*SW +: SW] = st;
    req_status_write[port]    = 1'b1;
    exp_status.push_back(st);
    step();
    check("status_latency", 128'(tx_fifo_status_write), 128'(1));
    check("grant_release", 128'(grant), 128'(0));
    req_status_write[port] = 1'b0;
    if (drop_req) req[port] = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic seen_to;
    logic [1:0] eg;

    pkts[0] = '{0, 5, 8'hA1, 2'b01};
    pkts[1] = '{1, 4, 8'h10, 2'b10};
    pkts[2] = '{0, 1, 8'hF0, 2'b01};
    fv[0] = '{1'b0, 1'b0, 2'b10, 2'b10};
    fv[1] = '{1'b0, 1'b1, 2'b10, 2'b11};
    fv[2] = '{1'b1, 1'b1, 2'b11, 2'b11};
    fv[3] = '{1'b1, 1'b0, 2'b11, 2'b10};

    // Reset state
    step(); step(); step();
    check("rst_grant", 128'(grant), 128'(0));
    check("rst_tx_dw", 128'(tx_fifo_data_write), 128'(0));
    check("rst_tx_sw", 128'(tx_fifo_status_write), 128'(0));
    check("rst_tx_data", 128'(tx_fifo_data), 128'(0));
    check("rst_errs", 128'({drop_err, timeout_err}), 128'(0));
    check("rst_rdf", 128'(req_data_full), 128'(2'b11));
    check("rst_rsf", 128'(req_status_full), 128'(2'b11));
    reset = 1'b0;
    step();

    // Single-requester packets: grant one cycle after req, 1-cycle forwarding.
    foreach (pkts[i]) begin
      req[pkts[i].port] = 1'b1;
      step();
      check("grant_latency", 128'(grant), 128'(pkts[i].exp_grant));
      send_body(pkts[i].port, pkts[i].len, pkts[i].base, 1'b1);
      step();
    end

    // Both ports requesting continuously.
    pulse_reset();
    req = 2'b11;
    for (int p = 0; p < 4; p++) begin
`ifdef PRIO_PORT0_EN
      eg = 2'b01;
`else
      eg = (p % 2 == 0) ? 2'b01 : 2'b10;
`endif
      wait_grant(eg, "arb_order");
      send_body(grant[1] ? 1 : 0, 3, 8'h30 + 8'(p * 16), 1'b0);
    end
    req[0] = 1'b0;
    wait_grant(2'b10, "port1_alone");
    send_body(1, 2, 8'h90, 1'b1);
    step();

    // Write from the non-granted port is dropped.
    req[0] = 1'b1;
    wait_grant(2'b01, "drop_grant");
    req_data[AW +: AW] = 8'h55;
    req_data_write[1]  = 1'b1;
    step();
    check("drop_no_fwd", 128'(tx_fifo_data_write), 128'(0));
    check("drop_err_pulse", 128'(drop_err), 128'(1));
    req_data_write[1] = 1'b0;
    step();
    check("drop_err_clear", 128'(drop_err), 128'(0));
    send_body(0, 2, 8'hC0, 1'b1);
    step();

    // Idle watchdog.
    req = 2'b01;
    wait_grant(2'b01, "to_grant");
    req[1] = 1'b1;
    cnt = 1;
    while (grant == 2'b01 && cnt < 40) begin
      step();
      if (grant == 2'b01) cnt++;
    end
    check("to_grant_cycles", 128'(cnt), 128'(MI));
    check("to_err_pulse", 128'(timeout_err), 128'(1));
    req[0] = 1'b0;
    step();
    check("to_err_clear", 128'(timeout_err), 128'(0));
    wait_grant(2'b10, "to_next_port");
    req[1] = 1'b0;
    step();
    check("abandon_release", 128'(grant), 128'(0));
    step();

    // Backpressure never times out; full outputs follow FIFO fulls and grant.
    req[0] = 1'b1;
    wait_grant(2'b01, "bp_grant");
    foreach (fv[i]) begin
      tx_fifo_data_full   = fv[i].df;
      tx_fifo_status_full = fv[i].sf;
      #1;
      check("req_data_full", 128'(req_data_full), 128'(fv[i].exp_rdf));
      check("req_status_full", 128'(req_status_full), 128'(fv[i].exp_rsf));
    end
    cnt = 0;
    seen_to = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (grant == 2'b01) cnt++;
      seen_to = seen_to | timeout_err;
    end
    check("bp_hold_grant", 128'(cnt), 128'(40));
    check("bp_no_timeout", 128'(seen_to), 128'(0));
    tx_fifo_data_full = 1'b0;
    req[0] = 1'b0;
    step();
    check("bp_release", 128'(grant), 128'(0));
    step();

    // Reset on the third byte of an 8-byte packet.
    req[0] = 1'b1;
    wait_grant(2'b01, "mr_grant");
    for (int b = 0; b < 3; b++) begin
      req_data[0 +: AW] = 8'hD0 + 8'(b);
      req_data_write[0] = 1'b1;
      if (b < 2) exp_data.push_back(8'hD0 + 8'(b));
      else reset = 1'b1;
      step();
    end
    check("mr_grant_clr", 128'(grant), 128'(0));
    check("mr_strobes_clr", 128'({tx_fifo_data_write, tx_fifo_status_write}), 128'(0));
    check("mr_data_clr", 128'(tx_fifo_data), 128'(0));
    reset = 1'b0;
    req = '0;
    req_data_write = '0;
    step();
    req = 2'b11;
    wait_grant(2'b01, "mr_rearb");
    send_body(0, 1, 8'hE0, 1'b1);
    wait_grant(2'b10, "mr_next");
    send_body(1, 1, 8'hE8, 1'b1);
    step();
    step();
    check("sb_data_empty", 128'(exp_data.size()), 128'(0));
    check("sb_status_empty", 128'(exp_status.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
